// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong paddle input path.
package pong_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEFAULT_CNT_WIDTH       = 20;

    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

endpackage

// File: rtl/paddle_input_conditioner_button_debouncer.sv
// One button: optional inversion, 2-flop synchroniser, counter debounce FSM, rise pulse.
// Build option: PADDLE_INPUT_ACTIVE_LOW_EN inverts the raw input (pressed = 0).
module button_debouncer
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic level_next_c,
    output logic rise_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 btn_in;
    logic                 sync1;
    logic                 sync2;
    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;

`ifdef PADDLE_INPUT_ACTIVE_LOW_EN
    assign btn_in = ~raw;
`else
    assign btn_in = raw;
`endif

    // Synchroniser resets to the released value so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RELEASED;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            level      <= level_next_c;
            rise_pulse <= level_next_c & ~level;
        end
    end

    // Counter only advances below CNT_MAX, so it saturates instead of wrapping.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RELEASED: begin
                if (sync2) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
        level_next_c = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

endmodule

// File: rtl/paddle_input_conditioner.sv
// Debounces both paddle buttons and arbitrates them (last pressed wins) into move requests.
// Build option: PADDLE_INPUT_ACTIVE_LOW_EN selects active-low raw buttons.
module paddle_input_conditioner
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic move_up_control,
    output logic move_down_control,
    output logic up_press_pulse,
    output logic down_press_pulse
);

    logic up_lvl;
    logic up_next_c;
    logic down_lvl;
    logic down_next_c;
    logic up_rise_c;
    logic down_rise_c;
    dir_e last_dir;
    dir_e dir_next;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_up (
        .clk         (clk),
        .rst         (rst),
        .raw         (btn_up_raw),
        .level       (up_lvl),
        .level_next_c(up_next_c),
        .rise_pulse  (up_press_pulse)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_down (
        .clk         (clk),
        .rst         (rst),
        .raw         (btn_down_raw),
        .level       (down_lvl),
        .level_next_c(down_next_c),
        .rise_pulse  (down_press_pulse)
    );

    // Arbitrate on next-cycle debounced levels so requests change with the debounced level.
    always_comb begin
        up_rise_c   = up_next_c & ~up_lvl;
        down_rise_c = down_next_c & ~down_lvl;
        dir_next    = last_dir;
        if (up_next_c && down_next_c) begin
            if (up_rise_c && down_rise_c) begin
                dir_next = DIR_NONE;
            end else if (up_rise_c) begin
                dir_next = DIR_UP;
            end else if (down_rise_c) begin
                dir_next = DIR_DOWN;
            end
        end else if (up_next_c) begin
            dir_next = DIR_UP;
        end else if (down_next_c) begin
            dir_next = DIR_DOWN;
        end else begin
            dir_next = DIR_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dir          <= DIR_NONE;
            move_up_control   <= 1'b0;
            move_down_control <= 1'b0;
        end else begin
            last_dir          <= dir_next;
            move_up_control   <= (dir_next == DIR_UP);
            move_down_control <= (dir_next == DIR_DOWN);
        end
    end

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Directed bench for paddle_input_conditioner (DEBOUNCE_CYCLES=4, CNT_WIDTH=3).
module tb_paddle_input_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn_up_raw;
    logic btn_down_raw;
    logic move_up_control;
    logic move_down_control;
    logic up_press_pulse;
    logic down_press_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    paddle_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_up_raw       (btn_up_raw),
        .btn_down_raw     (btn_down_raw),
        .move_up_control  (move_up_control),
        .move_down_control(move_down_control),
        .up_press_pulse   (up_press_pulse),
        .down_press_pulse (down_press_pulse)
    );

    // Logical press levels mapped to the raw polarity of this build.
    task automatic set_btns(input logic up, input logic down);
`ifdef PADDLE_INPUT_ACTIVE_LOW_EN
        btn_up_raw   = ~up;
        btn_down_raw = ~down;
`else
        btn_up_raw   = up;
        btn_down_raw = down;
`endif
    endtask

    // Advance one edge, sample 1ns later, and enforce the both-high invariant.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if ((move_up_control & move_down_control) !== 1'b0) begin
            errors++;
            $display("FAIL invariant up=%b down=%b t=%0t", move_up_control, move_down_control, $time);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_btns(1'b0, 1'b0);
        ticks(2);
        checks++;
        if ({move_up_control, move_down_control, up_press_pulse, down_press_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {move_up_control, move_down_control, up_press_pulse, down_press_pulse});
        end
        rst = 1'b0;
        ticks(2);
    endtask

    task automatic test_clean_press();
        set_btns(1'b1, 1'b0);
        ticks(6);
        checks++;
        if ({move_up_control, up_press_pulse} !== 2'b00) begin
            errors++;
            $display("FAIL press_edge6 got=%b exp=00", {move_up_control, up_press_pulse});
        end
        tick();
        checks++;
        if ({move_up_control, up_press_pulse, move_down_control, down_press_pulse} !== 4'b1100) begin
            errors++;
            $display("FAIL press_edge7 got=%b exp=1100",
                     {move_up_control, up_press_pulse, move_down_control, down_press_pulse});
        end
        tick();
        checks++;
        if ({move_up_control, up_press_pulse} !== 2'b10) begin
            errors++;
            $display("FAIL press_edge8 got=%b exp=10", {move_up_control, up_press_pulse});
        end
        ticks(3);
    endtask

    task automatic test_release_latency();
        set_btns(1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (move_up_control !== (i < 7) || up_press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL release_edge%0d got up=%b pulse=%b exp up=%b pulse=0",
                         i, move_up_control, up_press_pulse, (i < 7));
            end
        end
        ticks(3);
    endtask

    task automatic test_bounce();
        set_btns(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) set_btns(1'b0, 1'b0);
            if (i == 4) set_btns(1'b1, 1'b0);
            tick();
            checks++;
            if ({move_up_control, up_press_pulse} !== 2'b00) begin
                errors++;
                $display("FAIL bounce_cycle%0d got=%b exp=00", i, {move_up_control, up_press_pulse});
            end
        end
        tick();
        checks++;
        if ({move_up_control, up_press_pulse} !== 2'b11) begin
            errors++;
            $display("FAIL bounce_assert got=%b exp=11", {move_up_control, up_press_pulse});
        end
        set_btns(1'b0, 1'b0);
        ticks(10);
    endtask

    task automatic test_overlap();
        set_btns(1'b1, 1'b0);
        ticks(7);
        checks++;
        if (move_up_control !== 1'b1) begin
            errors++;
            $display("FAIL overlap_up_held got=%b exp=1", move_up_control);
        end
        set_btns(1'b1, 1'b1);
        ticks(6);
        checks++;
        if ({move_up_control, move_down_control} !== 2'b10) begin
            errors++;
            $display("FAIL overlap_down_edge6 got=%b exp=10", {move_up_control, move_down_control});
        end
        tick();
        checks++;
        if ({move_up_control, move_down_control, up_press_pulse, down_press_pulse} !== 4'b0101) begin
            errors++;
            $display("FAIL overlap_down_edge7 got=%b exp=0101",
                     {move_up_control, move_down_control, up_press_pulse, down_press_pulse});
        end
        ticks(2);
        set_btns(1'b1, 1'b0);
        ticks(6);
        checks++;
        if ({move_up_control, move_down_control} !== 2'b01) begin
            errors++;
            $display("FAIL overlap_rel_edge6 got=%b exp=01", {move_up_control, move_down_control});
        end
        tick();
        checks++;
        if ({move_up_control, move_down_control, up_press_pulse} !== 3'b100) begin
            errors++;
            $display("FAIL overlap_rel_edge7 got=%b exp=100",
                     {move_up_control, move_down_control, up_press_pulse});
        end
        set_btns(1'b0, 1'b0);
        ticks(10);
    endtask

    task automatic test_simultaneous();
        set_btns(1'b1, 1'b1);
        ticks(7);
        checks++;
        if ({move_up_control, move_down_control, up_press_pulse, down_press_pulse} !== 4'b0011) begin
            errors++;
            $display("FAIL simul_edge7 got=%b exp=0011",
                     {move_up_control, move_down_control, up_press_pulse, down_press_pulse});
        end
        ticks(3);
        checks++;
        if ({move_up_control, move_down_control} !== 2'b00) begin
            errors++;
            $display("FAIL simul_held got=%b exp=00", {move_up_control, move_down_control});
        end
        set_btns(1'b1, 1'b0);
        ticks(6);
        checks++;
        if ({move_up_control, move_down_control} !== 2'b00) begin
            errors++;
            $display("FAIL simul_rel_edge6 got=%b exp=00", {move_up_control, move_down_control});
        end
        tick();
        checks++;
        if ({move_up_control, move_down_control, up_press_pulse} !== 3'b100) begin
            errors++;
            $display("FAIL simul_rel_edge7 got=%b exp=100",
                     {move_up_control, move_down_control, up_press_pulse});
        end
        set_btns(1'b0, 1'b0);
        ticks(10);
    endtask

    task automatic test_reset_mid();
        int pulses;
        set_btns(1'b1, 1'b0);
        ticks(4);
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1;
            tick();
            checks++;
            if ({move_up_control, up_press_pulse} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid%0d_during got=%b exp=00", pass, {move_up_control, up_press_pulse});
            end
            tick();
            rst = 1'b0;
            pulses = 0;
            for (int i = 1; i <= 10; i++) begin
                tick();
                if (up_press_pulse === 1'b1) pulses++;
                checks++;
                if (move_up_control !== (i >= 7)) begin
                    errors++;
                    $display("FAIL rstmid%0d_edge%0d got=%b exp=%b", pass, i, move_up_control, (i >= 7));
                end
            end
            checks++;
            if (pulses != 1) begin
                errors++;
                $display("FAIL rstmid%0d_pulses got=%0d exp=1", pass, pulses);
            end
        end
        set_btns(1'b0, 1'b0);
        ticks(10);
    endtask

    initial begin
        rst = 1'b1;
        set_btns(1'b0, 1'b0);
        test_reset();
        test_clean_press();
        test_release_latency();
        test_bounce();
        test_overlap();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
